regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file with an integrated busy scoreboard.
- Successor to the fixed 32x32, 2-read/1-write register file used by the pipeline.
- Adds configurable width, depth and read-port count, a second write port, optional write-to-read bypass, and per-register pending bits for hazard detection.
- Sits between decode (reads, issue) and writeback (two writeback lanes).

Parameters:
DW, 32, data width in bits
AW, 5, address width; depth = 2**AW entries
NRD, 2, number of read ports
ZERO_REG, 1, 1 = entry 0 reads as 0, ignores writes and is never busy
BYPASS, 1, 1 = a read of an address being written this cycle returns the write data

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
ra  in  NRD*AW  read addresses, port i at bits [i*AW +: AW]
rd  out  NRD*DW  read data, port i at bits [i*DW +: DW]
rbusy  out  NRD  pending bit of the entry addressed by read port i
we0  in  1  write enable, lane 0
wa0  in  AW  write address, lane 0
wd0  in  DW  write data, lane 0
we1  in  1  write enable, lane 1; priority over lane 0
wa1  in  AW  write address, lane 1
wd1  in  DW  write data, lane 1
iss_v  in  1  issue: mark entry iss_a pending
iss_a  in  AW  destination of the issued instruction
busy_any  out  1  OR of all pending bits
busy_cnt  out  AW+1  number of entries currently pending

Behaviour:
- Reset (asynchronous, whenever rst=1):
  - All entries are 0 and all pending bits are 0.
  - Writes and issues are ignored.
  - Outputs while in reset: rd=0, rbusy=0, busy_any=0, busy_cnt=0.
  - A reset asserted mid-stream discards any same-edge write or issue.
- Writes:
  - On rising clk with rst=0, we0 writes wd0 to wa0 and we1 writes wd1 to wa1.
  - If both lanes target the same address, lane 1 wins and lane 0 has no effect.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Reads: combinational, zero latency.
  - rd[i] is the stored value of ra[i].
  - ZERO_REG=1 and ra[i]=0: rd[i]=0.
  - BYPASS=1 and rst=0: if we1 and wa1==ra[i], rd[i]=wd1. Otherwise, if we0 and wa0==ra[i], rd[i]=wd0. Otherwise rd[i] is the stored value. Address 0 is still forced to 0.
  - BYPASS=0: rd[i] shows the new value from the cycle after the write edge.
- Scoreboard, per entry, on each rising edge with rst=0:
  - A write on either lane to the entry clears its pending bit.
  - iss_v with iss_a equal to the entry sets its pending bit.
  - Issue and write to the same entry on the same edge: set wins (a new producer supersedes the old one).
  - Issuing to an already-pending entry leaves it pending; there is no count per entry.
  - Writing to a non-pending entry is legal; the bit stays 0.
  - ZERO_REG=1: entry 0 is never pending.
- rbusy[i] is combinational from the registered pending bits.
  - When BYPASS=1, rbusy[i] is forced to 0 if a write to ra[i] is present this cycle (the data is already valid through the bypass).
- busy_cnt / busy_any:
  - Both are registered, updated on the same edge as the pending bits, and reflect the post-edge pending set.
  - busy_cnt is in the range 0..2**AW and is exact; there is no saturation logic.
- No X propagation: out-of-range conditions cannot occur because every address is in range by width.

Test Plan:
- Reset while entries hold data: write 0xDEADBEEF to r5, assert rst between edges -> rd for r5 reads 0 immediately, before any edge; busy_cnt=0.
- Dual-write collision: we0/we1 both to r7 with wd0=0x11, wd1=0x22 -> r7=0x22 after the edge; with BYPASS=1, rd for r7 shows 0x22 in the same cycle.
- Zero register: write 0xFFFFFFFF to r0 and issue r0 -> rd=0, rbusy=0, busy_cnt unchanged.
- Scoreboard: issue r3, then r4 on successive cycles -> busy_cnt 1, then 2. Then write r3 and issue r3 on the same edge -> r3 still pending, busy_cnt=2. Then write r3 and r4 on both lanes -> busy_cnt=0, busy_any=0.
- Bypass-off build (BYPASS=0, NRD=4, DW=16, AW=3): write 0x1234 to r2 and read r2 on all 4 ports -> old value this cycle, 0x1234 on all ports the next cycle; rbusy tracks the pending bit without the forced clear.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with two writeback lanes, optional write-to-read bypass
// and a per-entry pending scoreboard with registered busy count.
module regfile_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*DW-1:0] rd,
  output logic [NRD-1:0]    rbusy,
  input  logic              we0,
  input  logic [AW-1:0]     wa0,
  input  logic [DW-1:0]     wd0,
  input  logic              we1,
  input  logic [AW-1:0]     wa1,
  input  logic [DW-1:0]     wd1,
  input  logic              iss_v,
  input  logic [AW-1:0]     iss_a,
  output logic              busy_any,
  output logic [AW:0]       busy_cnt
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    r_mem [DEPTH];
  logic [DEPTH-1:0] r_pend;
  logic [AW:0]      r_busy_cnt;
  logic             r_busy_any;

  logic [DEPTH-1:0] w_pend_nxt;
  logic [AW:0]      w_cnt_nxt;
  logic             w_we0;
  logic             w_we1;
  logic             w_iss;

  // Writes and issues aimed at the hard-wired zero entry are dropped up front.
  assign w_we0 = we0   && !((ZERO_REG != 0) && (wa0   == '0));
  assign w_we1 = we1   && !((ZERO_REG != 0) && (wa1   == '0));
  assign w_iss = iss_v && !((ZERO_REG != 0) && (iss_a == '0));

  // NOTE: the storage array is reset like any other flop because a reset must
  // make every entry read back as zero; this rules out a plain RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments, last one wins: lane 1 is written after
      // lane 0 so it takes the entry on an address collision.
      if (w_we0) r_mem[wa0] <= wd0;
      if (w_we1) r_mem[wa1] <= wd1;
    end
  end

  // Next pending set: writes clear, issue sets afterwards so a new producer wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_pend_nxt = r_pend;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_we0 && (wa0 == AW'(i)))   w_pend_nxt[i] = 1'b0;
      if (w_we1 && (wa1 == AW'(i)))   w_pend_nxt[i] = 1'b0;
      if (w_iss && (iss_a == AW'(i))) w_pend_nxt[i] = 1'b1;
    end
    if (ZERO_REG != 0) w_pend_nxt[0] = 1'b0;
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) w_cnt_nxt = w_cnt_nxt + (AW+1)'(w_pend_nxt[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend     <= '0;
      r_busy_cnt <= '0;
      r_busy_any <= 1'b0;
    end else begin
      r_pend     <= w_pend_nxt;
      r_busy_cnt <= w_cnt_nxt;
      r_busy_any <= |w_pend_nxt;
    end
  end

  assign busy_cnt = r_busy_cnt;
  assign busy_any = r_busy_any;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic [DW-1:0] w_data;
    logic          w_busy;

    assign w_ra = ra[p*AW +: AW];

    // A write landing this cycle makes the entry's data valid through the bypass.
    always_comb begin
      w_data = r_mem[w_ra];
      w_busy = r_pend[w_ra];
      if ((BYPASS != 0) && !rst) begin
        if (we1 && (wa1 == w_ra)) begin
          w_data = wd1;
          w_busy = 1'b0;
        end else if (we0 && (wa0 == w_ra)) begin
          w_data = wd0;
          w_busy = 1'b0;
        end
      end
      if ((ZERO_REG != 0) && (w_ra == '0)) begin
        w_data = '0;
        w_busy = 1'b0;
      end
    end

    assign rd[p*DW +: DW] = w_data;
    assign rbusy[p]       = w_busy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised bench for regfile_mp: a bypassing 32x32/2-port build and a
// non-bypassing 8x16/4-port build, both checked against an array-based model.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Build A: defaults (DW=32, AW=5, NRD=2, BYPASS=1)
  logic [9:0]  a_ra = '0;
  logic [63:0] a_rd;
  logic [1:0]  a_rbusy;
  logic        a_we0 = 0, a_we1 = 0, a_iss = 0;
  logic [4:0]  a_wa0 = '0, a_wa1 = '0, a_ia = '0;
  logic [31:0] a_wd0 = '0, a_wd1 = '0;
  logic        a_any;
  logic [5:0]  a_cnt;

  // Build B: DW=16, AW=3, NRD=4, BYPASS=0
  logic [11:0] b_ra = '0;
  logic [63:0] b_rd;
  logic [3:0]  b_rbusy;
  logic        b_we0 = 0, b_we1 = 0, b_iss = 0;
  logic [2:0]  b_wa0 = '0, b_wa1 = '0, b_ia = '0;
  logic [15:0] b_wd0 = '0, b_wd1 = '0;
  logic        b_any;
  logic [3:0]  b_cnt;

  regfile_mp u_a (
    .clk(clk), .rst(rst), .ra(a_ra), .rd(a_rd), .rbusy(a_rbusy),
    .we0(a_we0), .wa0(a_wa0), .wd0(a_wd0), .we1(a_we1), .wa1(a_wa1), .wd1(a_wd1),
    .iss_v(a_iss), .iss_a(a_ia), .busy_any(a_any), .busy_cnt(a_cnt)
  );

  regfile_mp #(.DW(16), .AW(3), .NRD(4), .ZERO_REG(1), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .ra(b_ra), .rd(b_rd), .rbusy(b_rbusy),
    .we0(b_we0), .wa0(b_wa0), .wd0(b_wd0), .we1(b_we1), .wa1(b_wa1), .wd1(b_wd1),
    .iss_v(b_iss), .iss_a(b_ia), .busy_any(b_any), .busy_cnt(b_cnt)
  );

  typedef struct packed {
    logic            we0, we1, iss;
    logic [4:0]      wa0, wa1, ia;
    logic [31:0]     wd0, wd1;
    logic [3:0][4:0] ra;
  } stim_t;

  stim_t sa, sb;
  logic  rst_v;

  logic [31:0] m_mem  [2][32];
  logic        m_pend [2][32];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int depth(int k);       return (k == 0) ? 32 : 8; endfunction
  function automatic logic [31:0] dmask(int k); return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF; endfunction
  function automatic bit byp(int k);         return k == 0; endfunction

  function automatic void m_reset(int k);
    for (int i = 0; i < 32; i++) begin
      m_mem[k][i]  = '0;
      m_pend[k][i] = 1'b0;
    end
  endfunction

  function automatic logic [31:0] m_rd(int k, stim_t s, int a);
    if (rst || a == 0) return '0;
    if (byp(k) && s.we1 && int'(s.wa1) == a) return s.wd1 & dmask(k);
    if (byp(k) && s.we0 && int'(s.wa0) == a) return s.wd0 & dmask(k);
    return m_mem[k][a];
  endfunction

  function automatic logic m_busy(int k, stim_t s, int a);
    if (a == 0) return 1'b0;
    if (byp(k) && ((s.we1 && int'(s.wa1) == a) || (s.we0 && int'(s.wa0) == a))) return 1'b0;
    return m_pend[k][a];
  endfunction

  function automatic int m_cnt(int k);
    int n = 0;
    for (int i = 0; i < depth(k); i++) n += int'(m_pend[k][i]);
    return n;
  endfunction

  function automatic void m_step(int k, stim_t s);
    if (s.we0 && s.wa0 != 0) m_mem[k][s.wa0] = s.wd0 & dmask(k);
    if (s.we1 && s.wa1 != 0) m_mem[k][s.wa1] = s.wd1 & dmask(k);
    if (s.we0) m_pend[k][s.wa0] = 1'b0;
    if (s.we1) m_pend[k][s.wa1] = 1'b0;
    if (s.iss) m_pend[k][s.ia]  = 1'b1;
    m_pend[k][0] = 1'b0;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic logic [4:0] rnd_addr(int k);
    logic [4:0] am;
    am = (k == 0) ? 5'd31 : 5'd7;
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 3));
    return 5'($urandom) & am;
  endfunction

  function automatic stim_t rnd(int k);
    stim_t s;
    s.we0 = 1'($urandom_range(0, 1));
    s.we1 = 1'($urandom_range(0, 1));
    s.iss = 1'($urandom_range(0, 1));
    s.wa0 = rnd_addr(k);
    s.wa1 = rnd_addr(k);
    s.ia  = rnd_addr(k);
    s.wd0 = $urandom & dmask(k);
    s.wd1 = $urandom & dmask(k);
    for (int i = 0; i < 4; i++) s.ra[i] = rnd_addr(k);
    return s;
  endfunction

  task automatic drive();
    a_we0 = sa.we0; a_wa0 = sa.wa0; a_wd0 = sa.wd0;
    a_we1 = sa.we1; a_wa1 = sa.wa1; a_wd1 = sa.wd1;
    a_iss = sa.iss; a_ia  = sa.ia;
    a_ra  = {sa.ra[1], sa.ra[0]};
    b_we0 = sb.we0; b_wa0 = sb.wa0[2:0]; b_wd0 = sb.wd0[15:0];
    b_we1 = sb.we1; b_wa1 = sb.wa1[2:0]; b_wd1 = sb.wd1[15:0];
    b_iss = sb.iss; b_ia  = sb.ia[2:0];
    b_ra  = {sb.ra[3][2:0], sb.ra[2][2:0], sb.ra[1][2:0], sb.ra[0][2:0]};
  endtask

  // Drive on the falling edge, then compare every output against the model.
  task automatic drive_check();
    @(negedge clk);
    rst = rst_v;
    if (rst_v) begin
      m_reset(0);
      m_reset(1);
    end
    drive();
    #1;
    for (int p = 0; p < 2; p++) begin
      check($sformatf("a_rd%0d", p), a_rd[p*32 +: 32], m_rd(0, sa, int'(sa.ra[p])));
      check($sformatf("a_rbusy%0d", p), a_rbusy[p], m_busy(0, sa, int'(sa.ra[p])));
    end
    check("a_cnt", a_cnt, m_cnt(0));
    check("a_any", a_any, m_cnt(0) != 0);
    for (int p = 0; p < 4; p++) begin
      check($sformatf("b_rd%0d", p), b_rd[p*16 +: 16], m_rd(1, sb, int'(sb.ra[p])));
      check($sformatf("b_rbusy%0d", p), b_rbusy[p], m_busy(1, sb, int'(sb.ra[p])));
    end
    check("b_cnt", b_cnt, m_cnt(1));
    check("b_any", b_any, m_cnt(1) != 0);
  endtask

  task automatic edge_step();
    @(posedge clk);
    if (!rst) begin
      m_step(0, sa);
      m_step(1, sb);
    end
  endtask

  task automatic cyc();
    drive_check();
    edge_step();
  endtask

  initial begin
    m_reset(0);
    m_reset(1);
    sa = idle();
    sb = rnd(1);
    rst_v = 1'b1;
    sa = rnd(0);
    cyc();
    cyc();
    rst_v = 1'b0;

    // Reset while an entry holds data and a register is pending
    sa = idle(); sb = idle();
    sa.we0 = 1; sa.wa0 = 5'd5; sa.wd0 = 32'hDEAD_BEEF; sa.iss = 1; sa.ia = 5'd9; sa.ra[0] = 5'd5;
    cyc();
    sa = idle(); sa.ra[0] = 5'd5;
    drive_check();
    check("r5_held", a_rd[31:0], 32'hDEAD_BEEF);
    check("pre_rst_cnt", a_cnt, 6'd1);
    edge_step();
    rst_v = 1'b1;
    drive_check();
    check("r5_in_rst", a_rd[31:0], 32'h0);
    check("cnt_in_rst", a_cnt, 6'd0);
    edge_step();
    rst_v = 1'b0;

    // Dual-write collision on r7
    sa = idle();
    sa.we0 = 1; sa.wa0 = 5'd7; sa.wd0 = 32'h11;
    sa.we1 = 1; sa.wa1 = 5'd7; sa.wd1 = 32'h22; sa.ra[0] = 5'd7;
    drive_check();
    check("coll_bypass", a_rd[31:0], 32'h22);
    edge_step();
    sa = idle(); sa.ra[0] = 5'd7;
    drive_check();
    check("coll_stored", a_rd[31:0], 32'h22);
    edge_step();

    // Zero register ignores writes and issues
    sa = idle();
    sa.we0 = 1; sa.wa0 = 5'd0; sa.wd0 = 32'hFFFF_FFFF; sa.iss = 1; sa.ia = 5'd0;
    drive_check();
    check("zero_rd", a_rd[31:0], 32'h0);
    check("zero_rbusy", a_rbusy[0], 1'b0);
    edge_step();
    sa = idle();
    drive_check();
    check("zero_rd_after", a_rd[31:0], 32'h0);
    check("zero_cnt", a_cnt, 6'd0);
    edge_step();

    // Scoreboard sequence
    sa = idle(); sa.iss = 1; sa.ia = 5'd3;
    cyc();
    sa.ia = 5'd4;
    drive_check();
    check("sb_cnt1", a_cnt, 6'd1);
    edge_step();
    sa = idle();
    sa.we0 = 1; sa.wa0 = 5'd3; sa.wd0 = 32'h33; sa.iss = 1; sa.ia = 5'd3; sa.ra[0] = 5'd3;
    drive_check();
    check("sb_cnt2", a_cnt, 6'd2);
    edge_step();
    sa = idle(); sa.ra[0] = 5'd3; sa.ra[1] = 5'd4;
    drive_check();
    check("sb_set_wins", a_rbusy, 2'b11);
    check("sb_cnt_still2", a_cnt, 6'd2);
    edge_step();
    sa.we0 = 1; sa.wa0 = 5'd3; sa.wd0 = 32'h3;
    sa.we1 = 1; sa.wa1 = 5'd4; sa.wd1 = 32'h4;
    cyc();
    sa = idle();
    drive_check();
    check("sb_cnt0", a_cnt, 6'd0);
    check("sb_any0", a_any, 1'b0);
    edge_step();

    // Bypass-off build: old value this cycle, new value next cycle
    sa = idle(); sb = idle();
    sb.we0 = 1; sb.wa0 = 5'd2; sb.wd0 = 32'hAAAA; sb.iss = 1; sb.ia = 5'd2;
    cyc();
    sb = idle();
    sb.we0 = 1; sb.wa0 = 5'd2; sb.wd0 = 32'h1234;
    for (int i = 0; i < 4; i++) sb.ra[i] = 5'd2;
    drive_check();
    for (int p = 0; p < 4; p++) check($sformatf("b_old%0d", p), b_rd[p*16 +: 16], 16'hAAAA);
    check("b_busy_old", b_rbusy, 4'hF);
    edge_step();
    sb.we0 = 0;
    drive_check();
    for (int p = 0; p < 4; p++) check($sformatf("b_new%0d", p), b_rd[p*16 +: 16], 16'h1234);
    check("b_busy_new", b_rbusy, 4'h0);
    edge_step();

    // Randomised traffic with occasional resets
    for (int n = 0; n < 1500; n++) begin
      rst_v = ($urandom_range(0, 63) == 0);
      sa = rnd(0);
      sb = rnd(1);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
